// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Bytes are captured on each rising edge of rx_done.
// The head byte falls through to r_data, and overrun is a sticky flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_dato_out,
  input  logic              rx_done,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              rx_done_q;
  logic              push_req, push, pop, drop, empty, full;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
  assign push_req = rx_done & ~rx_done_q;
  assign pop      = rd & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // rx_done_q resets high so that an rx_done already asserted at release does not count as a new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rx_done_q <= 1'b1;
    end else begin
      rx_done_q <= rx_done;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_dato_out;
  end

  assign r_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign rx_empty = empty;
  assign rx_full  = full;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference model is compared on every falling edge,
// alongside hand-computed literal expectations.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_dato_out;
  logic       rx_done;
  logic       rd;
  logic       clr_overrun;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rx_full;
  logic [4:0] count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .rx_dato_out(rx_dato_out), .rx_done(rx_done),
    .rd(rd), .clr_overrun(clr_overrun), .r_data(r_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .count(count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored bytes, a sticky overrun bit and the previous rx_done level.
  byte unsigned mq[$];
  bit           m_ov;
  bit           m_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ov   = 1'b0;
      m_prev = 1'b1;
    end else begin
      bit req, dropped;
      req     = rx_done && !m_prev;
      dropped = 1'b0;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (req) begin
        if (mq.size() < 16) mq.push_back(rx_dato_out);
        else dropped = 1'b1;
      end
      if (dropped)          m_ov = 1'b1;
      else if (clr_overrun) m_ov = 1'b0;
      m_prev = rx_done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model_r_data", r_data, (mq.size() > 0) ? mq[0] : 8'h00);
      check("model_count", count, mq.size());
      check("model_empty", rx_empty, mq.size() == 0);
      check("model_full", rx_full, mq.size() == 16);
      check("model_overrun", overrun, m_ov);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_dato_out = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_dato_out = 8'hXX;
    tick();
  endtask

  task automatic pop_one(output logic [7:0] got);
    got = r_data;
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  logic [7:0] got;

  initial begin
    reset = 1'b1; rx_done = 1'b1; rd = 1'b0; clr_overrun = 1'b0; rx_dato_out = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("rst_count", count, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_r_data", r_data, 8'h00);
    check("rst_overrun", overrun, 0);
    rx_done = 1'b0; tick();
    rx_dato_out = 8'hA5; rx_done = 1'b1; tick();
    check("a5_r_data", r_data, 8'hA5);
    check("a5_count", count, 1);
    rx_done = 1'b0; tick();
    pop_one(got);

    rx_dato_out = 8'h3C; rx_done = 1'b1;
    repeat (10) tick();
    rx_done = 1'b0; tick();
    check("hold_count", count, 1);
    check("hold_r_data", r_data, 8'h3C);
    pop_one(got);
    check("hold_pop_empty", rx_empty, 1);
    check("hold_pop_r_data", r_data, 8'h00);
    pop_one(got);
    check("rd_empty_count", count, 0);

    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("fill_full", rx_full, 1);
    check("fill_count", count, 16);
    push_byte(8'h55);
    check("drop_overrun", overrun, 1);
    check("drop_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      pop_one(got);
      check("drain_order", got, i);
    end
    check("drain_empty", rx_empty, 1);
    check("ov_sticky", overrun, 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check("ov_clear", overrun, 0);

    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    rx_dato_out = 8'h77; rx_done = 1'b1; rd = 1'b1; tick();
    rx_done = 1'b0; rd = 1'b0;
    check("fullpp_count", count, 16);
    check("fullpp_overrun", overrun, 0);
    for (int i = 0; i < 15; i++) begin
      pop_one(got);
      check("fullpp_order", got, 8'h11 + i);
    end
    pop_one(got);
    check("fullpp_last", got, 8'h77);
    check("fullpp_empty", rx_empty, 1);

    push_byte(8'h80);
    push_byte(8'h81);
    for (int i = 0; i < 40; i++) begin
      check("wrap_head", r_data, 8'h80 + i);
      got = r_data;
      if (i + 2 < 40) begin
        rx_dato_out = 8'h80 + 8'(i + 2);
        rx_done = 1'b1;
      end
      rd = 1'b1; tick();
      rx_done = 1'b0; rd = 1'b0; tick();
      check("wrap_pop", got, 8'h80 + i);
    end
    check("wrap_empty", rx_empty, 1);

    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    check("mid_count", count, 5);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("async_count", count, 0);
    check("async_empty", rx_empty, 1);
    check("async_r_data", r_data, 8'h00);
    check("async_full", rx_full, 0);
    tick();
    reset = 1'b0;
    tick();
    push_byte(8'hE1);
    check("post_rst_r_data", r_data, 8'hE1);
    check("post_rst_count", count, 1);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between the UART receiver (byte output plus done strobe) and its consumer (debug unit or CPU-side interface).
- Captures each received byte on the rising edge of the receiver's done signal and stores it in a circular FIFO.
- Presents the head byte first-word-fall-through, with empty, full, count and sticky overrun status.
- Keeps bytes from being lost when the consumer is busy, for example while the debug unit is driving the transmitter.

Parameters:
- DATA_W, 8, byte width; must match the receiver data width.
- ADDR_W, 4, log2 of FIFO depth; depth = 2**ADDR_W = 16 entries.

Ports:
- clk  input  1  system clock; the same clock that feeds the baud generator.
- reset  input  1  asynchronous, active-high reset.
- rx_dato_out  input  DATA_W  byte from the receiver; valid while rx_done is high.
- rx_done  input  1  receiver done flag; may stay high for several clk cycles; one byte per 0->1 transition.
- rd  input  1  pop strobe from the consumer; one byte popped per cycle while high.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- r_data  output  DATA_W  head byte (first-word-fall-through).
- rx_empty  output  1  FIFO holds 0 entries.
- rx_full  output  1  FIFO holds 2**ADDR_W entries.
- count  output  ADDR_W+1  number of stored entries, 0..2**ADDR_W.
- overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, synchronous deassert at the source):
  - wr_ptr = 0, rd_ptr = 0, count = 0, overrun = 0.
  - rx_empty = 1, rx_full = 0, r_data = 0.
  - Edge register rx_done_q resets to 1, so an rx_done already high at reset release is not taken as a new byte.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored bytes immediately.
- Edge detect: push_req = rx_done & ~rx_done_q (combinational). rx_done_q <= rx_done every cycle.
- Push:
  - When push_req and (not full, or pop in the same cycle), the clk edge writes rx_dato_out to mem[wr_ptr].
  - wr_ptr then increments modulo 2**ADDR_W; pointers are ADDR_W bits and wrap naturally.
- Push to a full FIFO with no pop:
  - Byte is dropped and overrun <= 1.
  - Memory, pointers and count are unchanged.
- Pop:
  - rd & ~rx_empty advances rd_ptr modulo 2**ADDR_W.
  - rd while empty is ignored: no pointer change, no error flag.
- Count update per cycle:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
- Simultaneous push and pop:
  - When full: pop frees a slot, push is accepted, count stays 2**ADDR_W, overrun is not set.
  - When empty: pop is ignored, push is accepted, count becomes 1.
- Outputs:
  - rx_empty = (count == 0); rx_full = (count == 2**ADDR_W).
  - r_data = mem[rd_ptr] when not empty, 8'h00 when empty.
- Latency: a byte whose rx_done rising is sampled at edge N appears on r_data, with rx_empty = 0, immediately after edge N (1 cycle).
- Overrun:
  - Set only by a dropped byte.
  - Cleared by clr_overrun, or by reset, on the next edge.
  - If clr_overrun and a drop occur in the same cycle, set wins.
- rx_dato_out is sampled only in a push cycle; changes at other times have no effect.

Test Plan:
- Reset release with rx_done held high -> no push; count = 0, rx_empty = 1, r_data = 00. Drop rx_done, then raise it with data A5 -> after 1 edge r_data = A5, count = 1.
- Hold rx_done high 10 cycles with byte 3C -> exactly one entry stored, count = 1. Pulse rd once -> rx_empty = 1, r_data = 00.
- Push bytes 00..0F (16 pulses) -> rx_full = 1, count = 16. Push 55 -> dropped, overrun = 1, count = 16. Pop 16 times -> reads 00..0F in order. Assert clr_overrun -> overrun = 0.
- Full FIFO: push 77 and rd in the same cycle -> count stays 16, overrun = 0; after 15 further pops the last byte read is 77.
- Pointer wrap: 40 interleaved push/pop pairs with bytes 80..A7, occupancy kept at 1..3 -> output order matches input; wr_ptr and rd_ptr wrap past 15 without data loss.
- Reset asserted asynchronously mid-stream with count = 5 -> outputs return to reset values without a clock edge; the next push of E1 yields r_data = E1, count = 1.
